rtc_timer_sched: RTL and testbench
==================================

// Module: rtc_timer_sched
// PURPOSE
// Multiplexes N_TIMERS software deadlines onto the single RTC mtimecmp register.
// Keeps one 64-bit deadline per channel and compares each against mtime every cycle.
// Finds the earliest armed deadline, programs it into the RTC over the RTC bus, and
// raises a per-channel pending flag on expiry.
// Sits between the core's peripheral bus (cfg side) and the RTC (rtc_* side).
// PARAMETERS
// N_TIMERS  4   number of virtual timer channels (2..16); IW = $clog2(N_TIMERS)
// PORTS
// clk             in   1   core clock
// reset_n         in   1   synchronous active-low reset
// cfg_valid_i     in   1   config command valid; always accepted, no backpressure
// cfg_op_i        in   1   1 = arm channel with deadline, 0 = cancel channel
// cfg_idx_i       in   IW  target channel
// cfg_deadline_i  in   64  absolute deadline in mtime ticks (used when cfg_op_i = 1)
// ack_i           in   N   per-channel pending clear (write-1-to-clear)
// mtime_i         in   64  current mtime from RTC
// rtc_en_o        out  1   RTC access strobe, one cycle per write
// rtc_addr_o      out  4   RTC address; always 4'h8 (mtimecmp, 64-bit aligned)
// rtc_we_o        out  8   RTC byte enables; 8'hFF during a write, else 8'h00
// rtc_data_o      out  64  new mtimecmp value
// pending_o       out  N   per-channel expired flag
// busy_o          out  1   high while state != IDLE or a rescan is queued
// BEHAVIOUR
// Reset, sync, when reset_n = 0 at posedge:
// - armed, pending_o, dirty and rtc_en_o -> 0; rtc_we_o -> 0; rtc_addr_o -> 4'h8
// - rtc_data_o and prog_q (last programmed value) -> 64'hFFFF_FFFF_FFFF_FFFF
// - deadlines -> 0; state -> IDLE
// - Reset mid-scan or mid-write drops the operation; no RTC write is issued.
// Config (applies in the cycle after cfg_valid_i is sampled):
// - arm: deadline[idx] <= cfg_deadline_i, armed[idx] <= 1, pending[idx] unchanged
// - cancel: armed[idx] <= 0; pending is not cleared
// - both set dirty
// Expiry, parallel every cycle: armed[i] && mtime_i >= deadline[i] (unsigned 64-bit)
// -> next cycle pending[i] = 1, armed[i] = 0, dirty = 1.
// Collisions:
// - cfg to channel i and expiry of i in the same cycle: cfg wins; no pending set.
// - ack_i[i] and expiry of i in the same cycle: set wins; pending stays 1.
// - ack of a non-pending channel: no effect.
// FSM:
// - IDLE: if dirty -> SCAN, idx = 0, min = all-ones, dirty = 0.
// - SCAN: one channel per cycle; if armed[idx] && deadline[idx] < min then min = deadline[idx].
//   If dirty is set during SCAN, restart at idx = 0 with min = all-ones and clear dirty.
//   After idx = N_TIMERS-1: go to WRITE if min != prog_q, else go to IDLE.
// - WRITE: for exactly one cycle rtc_en_o = 1, rtc_we_o = FF, rtc_data_o = min;
//   prog_q = min; -> IDLE.
// No armed channel: min = all-ones, so mtimecmp is parked at 64'hFFFF_FFFF_FFFF_FFFF.
// Latency: cfg sampled at t -> SCAN t+2 .. t+1+N -> rtc_en_o high at t+2+N (if no restart).
// Equal deadlines: the lowest index is kept (strict <); the programmed value is identical.
// All rtc_* outputs and pending_o are registered; no combinational path from inputs.
// TESTING
// 1. Reset with cfg_valid_i and ack_i toggling -> pending_o = 0, rtc_en_o = 0, busy_o = 0,
//    and no RTC write for 10 cycles.
// 2. mtime = 10; arm ch1 @ 500 -> one write at cycle t+6 (N=4): addr 8, we FF, data 500.
// 3. Arm ch0 @ 900 and ch2 @ 300; mtime reaches 300 -> pending_o = 4'b0100;
//    rescan writes 900; ack_i = 4'b0100 -> pending_o = 0.
// 4. Arm ch3 @ 700, then cancel ch3 -> final write data 64'hFFFF_FFFF_FFFF_FFFF;
//    re-arm with an unchanged min -> no second write.
// 5. Arm ch0 @ 800; in SCAN cycle 2 arm ch1 @ 200 -> scan restarts;
//    a single write of 200 is issued and 800 is never written.
// 6. Arm ch2 @ 50 with mtime = 60 and assert ack_i[2] on the expiry cycle -> pending_o[2] = 1;
//    same-cycle cfg re-arm of ch2 @ 1000 -> pending stays 0, ch2 armed.

Source files
------------

// File: rtl/rtc_timer_sched.sv
// rtc_timer_sched: multiplexes N_TIMERS 64-bit software deadlines onto the
// single RTC mtimecmp register. Each channel's deadline is compared against
// mtime every cycle. A sequential scan finds the earliest armed deadline and
// programs it into the RTC. Expired channels raise a write-1-to-clear
// pending flag.
module rtc_timer_sched #(
  parameter  int unsigned N_TIMERS = 4,
  localparam int unsigned IW       = $clog2(N_TIMERS)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cfg_valid_i,
  input  logic                cfg_op_i,
  input  logic [IW-1:0]       cfg_idx_i,
  input  logic [63:0]         cfg_deadline_i,
  input  logic [N_TIMERS-1:0] ack_i,
  input  logic [63:0]         mtime_i,
  output logic                rtc_en_o,
  output logic [3:0]          rtc_addr_o,
  output logic [7:0]          rtc_we_o,
  output logic [63:0]         rtc_data_o,
  output logic [N_TIMERS-1:0] pending_o,
  output logic                busy_o
);

  typedef enum logic [1:0] {IDLE, SCAN, WRITE} state_e;

  logic [63:0]         deadline_q [N_TIMERS];
  logic [63:0]         deadline_d [N_TIMERS];
  logic [N_TIMERS-1:0] armed_q, armed_d;
  logic [N_TIMERS-1:0] pending_q, pending_d;
  logic [N_TIMERS-1:0] expired;
  logic                dirty_q, dirty_d, dirty_new;
  state_e              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [63:0]         min_q, min_d;
  logic [63:0]         prog_q, prog_d;
  logic [63:0]         cand;
  logic                rtc_en_q, rtc_en_d;
  logic [7:0]          rtc_we_q, rtc_we_d;
  logic [63:0]         rtc_data_q, rtc_data_d;

  // Per-channel update: config, expiry and acknowledge, with cfg beating expiry
  // and expiry beating ack on the same channel.
  always_comb begin
    deadline_d = deadline_q;
    armed_d    = armed_q;
    pending_d  = pending_q;
    expired    = '0;
    dirty_new  = 1'b0;
    for (int unsigned i = 0; i < N_TIMERS; i++) begin
      logic hit;
      logic set;
      expired[i]   = armed_q[i] && (mtime_i >= deadline_q[i]);
      hit          = cfg_valid_i && (cfg_idx_i == IW'(i));
      set          = expired[i] && !hit;
      pending_d[i] = (pending_q[i] && !ack_i[i]) || set;
      if (set) begin
        armed_d[i] = 1'b0;
        dirty_new  = 1'b1;
      end
      if (hit) begin
        armed_d[i] = cfg_op_i;
        if (cfg_op_i) deadline_d[i] = cfg_deadline_i;
        dirty_new  = 1'b1;
      end
    end
  end

  // Scan/write sequencer: walks channels one per cycle, restarts on any change,
  // and writes mtimecmp only when the minimum differs from the last programmed value.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    min_d      = min_q;
    prog_d     = prog_q;
    dirty_d    = dirty_q | dirty_new;
    rtc_en_d   = 1'b0;
    rtc_we_d   = 8'h00;
    rtc_data_d = rtc_data_q;
    cand       = (armed_q[idx_q] && (deadline_q[idx_q] < min_q)) ? deadline_q[idx_q] : min_q;
    unique case (state_q)
      IDLE: begin
        if (dirty_q) begin
          state_d = SCAN;
          idx_d   = '0;
          min_d   = '1;
          dirty_d = dirty_new;
        end
      end
      SCAN: begin
        if (dirty_q) begin
          idx_d   = '0;
          min_d   = '1;
          dirty_d = dirty_new;
        end else begin
          min_d = cand;
          if (idx_q == IW'(N_TIMERS - 1)) begin
            // Strobe is launched on the transition so it is high exactly while in WRITE.
            if (cand != prog_q) begin
              state_d    = WRITE;
              rtc_en_d   = 1'b1;
              rtc_we_d   = 8'hFF;
              rtc_data_d = cand;
            end else begin
              state_d = IDLE;
            end
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      WRITE: begin
        prog_d  = min_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < N_TIMERS; i++) deadline_q[i] <= '0;
      armed_q    <= '0;
      pending_q  <= '0;
      dirty_q    <= 1'b0;
      state_q    <= IDLE;
      idx_q      <= '0;
      min_q      <= '1;
      prog_q     <= '1;
      rtc_en_q   <= 1'b0;
      rtc_we_q   <= 8'h00;
      rtc_data_q <= '1;
    end else begin
      for (int unsigned i = 0; i < N_TIMERS; i++) deadline_q[i] <= deadline_d[i];
      armed_q    <= armed_d;
      pending_q  <= pending_d;
      dirty_q    <= dirty_d;
      state_q    <= state_d;
      idx_q      <= idx_d;
      min_q      <= min_d;
      prog_q     <= prog_d;
      rtc_en_q   <= rtc_en_d;
      rtc_we_q   <= rtc_we_d;
      rtc_data_q <= rtc_data_d;
    end
  end

  assign rtc_en_o   = rtc_en_q;
  assign rtc_addr_o = 4'h8;
  assign rtc_we_o   = rtc_we_q;
  assign rtc_data_o = rtc_data_q;
  assign pending_o  = pending_q;
  assign busy_o     = (state_q != IDLE) || dirty_q;

endmodule

// File: tb/tb_rtc_timer_sched.sv
// Directed testbench for rtc_timer_sched (N_TIMERS = 4).
module tb_rtc_timer_sched;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_op = 1'b0;
  logic [1:0]  cfg_idx = '0;
  logic [63:0] cfg_deadline = '0;
  logic [3:0]  ack = '0;
  logic [63:0] mtime = '0;
  logic        rtc_en;
  logic [3:0]  rtc_addr;
  logic [7:0]  rtc_we;
  logic [63:0] rtc_data;
  logic [3:0]  pending;
  logic        busy;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  logic [63:0] wr_data[$];
  int          wr_cyc[$];
  logic [3:0]  wr_addr[$];
  logic [7:0]  wr_we[$];

  rtc_timer_sched #(.N_TIMERS(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .cfg_valid_i(cfg_valid), .cfg_op_i(cfg_op), .cfg_idx_i(cfg_idx),
    .cfg_deadline_i(cfg_deadline), .ack_i(ack), .mtime_i(mtime),
    .rtc_en_o(rtc_en), .rtc_addr_o(rtc_addr), .rtc_we_o(rtc_we),
    .rtc_data_o(rtc_data), .pending_o(pending), .busy_o(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every RTC write strobe, sampled mid-cycle.
  always @(negedge clk) begin
    if (rtc_en === 1'b1) begin
      wr_data.push_back(rtc_data);
      wr_cyc.push_back(cyc);
      wr_addr.push_back(rtc_addr);
      wr_we.push_back(rtc_we);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wr_data.delete(); wr_cyc.delete(); wr_addr.delete(); wr_we.delete();
  endtask

  task automatic do_reset();
    reset_n = 1'b0; cfg_valid = 1'b0; ack = '0; mtime = '0;
    tick(); tick();
    reset_n = 1'b1;
    clear_log();
  endtask

  // Present one command; e is the cycle number right after it was sampled.
  task automatic cfg(input logic op, input logic [1:0] idx, input logic [63:0] dl, output int e);
    cfg_valid = 1'b1; cfg_op = op; cfg_idx = idx; cfg_deadline = dl;
    tick();
    e = cyc;
    cfg_valid = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    clear_log();
    for (int k = 0; k < 10; k++) begin
      cfg_valid = k[0]; cfg_op = 1'b1; cfg_idx = k[1:0]; cfg_deadline = '0;
      ack = k[3:0]; mtime = 64'd100;
      tick();
      tests_run++;
      if (pending !== 4'b0000) begin tests_failed++; $display("FAIL reset_pending k=%0d got %b want 0000", k, pending); end
      tests_run++;
      if (rtc_en !== 1'b0) begin tests_failed++; $display("FAIL reset_rtc_en k=%0d got %b want 0", k, rtc_en); end
      tests_run++;
      if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy k=%0d got %b want 0", k, busy); end
    end
    cfg_valid = 1'b0; ack = '0;
    tests_run++;
    if (wr_data.size() != 0) begin tests_failed++; $display("FAIL reset_no_write got %0d writes want 0", wr_data.size()); end
    tests_run++;
    if (rtc_data !== ONES) begin tests_failed++; $display("FAIL reset_data got %h want %h", rtc_data, ONES); end
    tests_run++;
    if (rtc_we !== 8'h00 || rtc_addr !== 4'h8) begin tests_failed++; $display("FAIL reset_we_addr got we=%h addr=%h want 00/8", rtc_we, rtc_addr); end
    reset_n = 1'b1;
    tick(); tick();
    tests_run++;
    if (busy !== 1'b0 || wr_data.size() != 0) begin tests_failed++; $display("FAIL reset_release got busy=%b writes=%0d want 0/0", busy, wr_data.size()); end
  endtask

  task automatic test_single_arm();
    int e; bit ok;
    do_reset();
    mtime = 64'd10;
    cfg(1'b1, 2'd1, 64'd500, e);
    wait_idle(ok);
    tick(); tick();
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL single_timeout got busy want idle"); end
    tests_run++;
    if (wr_data.size() != 1) begin tests_failed++; $display("FAIL single_count got %0d want 1", wr_data.size()); end
    else begin
      tests_run++;
      if (wr_data[0] !== 64'd500) begin tests_failed++; $display("FAIL single_data got %0d want 500", wr_data[0]); end
      tests_run++;
      if (wr_addr[0] !== 4'h8 || wr_we[0] !== 8'hFF) begin tests_failed++; $display("FAIL single_addr_we got %h/%h want 8/FF", wr_addr[0], wr_we[0]); end
      tests_run++;
      if (wr_cyc[0] != e + 5) begin tests_failed++; $display("FAIL single_latency got %0d want %0d", wr_cyc[0], e + 5); end
    end
  endtask

  task automatic test_expiry();
    int e; bit ok;
    do_reset();
    mtime = 64'd10;
    cfg(1'b1, 2'd0, 64'd900, e);
    cfg(1'b1, 2'd2, 64'd300, e);
    wait_idle(ok);
    tests_run++;
    if (!ok || wr_data.size() != 1 || wr_data[wr_data.size()-1] !== 64'd300) begin
      tests_failed++; $display("FAIL expiry_first got ok=%0d writes=%0d want one write of 300", ok, wr_data.size());
    end
    mtime = 64'd300;
    tick();
    tests_run++;
    if (pending !== 4'b0100) begin tests_failed++; $display("FAIL expiry_pending got %b want 0100", pending); end
    wait_idle(ok);
    tests_run++;
    if (!ok || wr_data.size() != 2 || wr_data[wr_data.size()-1] !== 64'd900) begin
      tests_failed++; $display("FAIL expiry_rescan got ok=%0d writes=%0d want second write of 900", ok, wr_data.size());
    end
    tests_run++;
    if (pending !== 4'b0100) begin tests_failed++; $display("FAIL expiry_hold got %b want 0100", pending); end
    ack = 4'b0100;
    tick();
    ack = '0;
    tests_run++;
    if (pending !== 4'b0000) begin tests_failed++; $display("FAIL expiry_ack got %b want 0000", pending); end
  endtask

  task automatic test_cancel();
    int e; bit ok;
    do_reset();
    mtime = 64'd10;
    cfg(1'b1, 2'd3, 64'd700, e);
    wait_idle(ok);
    cfg(1'b0, 2'd3, 64'd0, e);
    wait_idle(ok);
    tests_run++;
    if (!ok || wr_data.size() != 2 || wr_data[wr_data.size()-1] !== ONES) begin
      tests_failed++; $display("FAIL cancel_park got ok=%0d writes=%0d want second write of all-ones", ok, wr_data.size());
    end
    cfg(1'b1, 2'd3, 64'd700, e);
    wait_idle(ok);
    tests_run++;
    if (wr_data.size() != 3 || wr_data[wr_data.size()-1] !== 64'd700) begin
      tests_failed++; $display("FAIL cancel_rearm got writes=%0d want third write of 700", wr_data.size());
    end
    cfg(1'b1, 2'd0, 64'd900, e);
    wait_idle(ok);
    tick(); tick();
    tests_run++;
    if (!ok || wr_data.size() != 3) begin tests_failed++; $display("FAIL cancel_unchanged got writes=%0d want 3", wr_data.size()); end
  endtask

  task automatic test_restart();
    int e, e2; bit ok; bit seen800;
    do_reset();
    mtime = 64'd10;
    cfg(1'b1, 2'd0, 64'd800, e);
    tick(); tick();
    cfg(1'b1, 2'd1, 64'd200, e2);
    wait_idle(ok);
    tick(); tick();
    seen800 = 1'b0;
    for (int k = 0; k < wr_data.size(); k++) if (wr_data[k] == 64'd800) seen800 = 1'b1;
    tests_run++;
    if (seen800) begin tests_failed++; $display("FAIL restart_no800 got a write of 800 want none"); end
    tests_run++;
    if (!ok || wr_data.size() != 1) begin tests_failed++; $display("FAIL restart_count got %0d want 1", wr_data.size()); end
    else begin
      tests_run++;
      if (wr_data[0] !== 64'd200) begin tests_failed++; $display("FAIL restart_data got %0d want 200", wr_data[0]); end
      tests_run++;
      if (wr_cyc[0] != e + 8) begin tests_failed++; $display("FAIL restart_latency got %0d want %0d", wr_cyc[0], e + 8); end
    end
  endtask

  task automatic test_collisions();
    int e; bit ok;
    do_reset();
    mtime = 64'd60;
    ack = 4'b1011;
    tick();
    ack = '0;
    tests_run++;
    if (pending !== 4'b0000) begin tests_failed++; $display("FAIL coll_ack_idle got %b want 0000", pending); end
    cfg(1'b1, 2'd2, 64'd50, e);
    ack = 4'b0100;
    tick();
    ack = '0;
    tests_run++;
    if (pending !== 4'b0100) begin tests_failed++; $display("FAIL coll_set_wins got %b want 0100", pending); end
    ack = 4'b0100;
    tick();
    ack = '0;
    tests_run++;
    if (pending !== 4'b0000) begin tests_failed++; $display("FAIL coll_clear got %b want 0000", pending); end
    wait_idle(ok);
    clear_log();
    cfg(1'b1, 2'd2, 64'd50, e);
    cfg(1'b1, 2'd2, 64'd1000, e);
    tests_run++;
    if (pending !== 4'b0000) begin tests_failed++; $display("FAIL coll_cfg_wins got %b want 0000", pending); end
    wait_idle(ok);
    tests_run++;
    if (pending !== 4'b0000) begin tests_failed++; $display("FAIL coll_pending_later got %b want 0000", pending); end
    tests_run++;
    if (!ok || wr_data.size() != 1 || wr_data[wr_data.size()-1] !== 64'd1000) begin
      tests_failed++; $display("FAIL coll_rearm got ok=%0d writes=%0d want one write of 1000", ok, wr_data.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_arm();
    test_expiry();
    test_cancel();
    test_restart();
    test_collisions();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
